// File: rtl/fsqrt_issue_if.sv
// Core-side request/response bus of the fsqrt issue block.
// The core is the master: it presents requests and consumes responses.
// The issue block is the slave: it grants requests and presents results.
interface fsqrt_issue_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_x;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_y;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_exc;

    modport master (
        output req_valid, req_x, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_y, resp_tag, resp_exc
    );

    modport slave (
        input  req_valid, req_x, req_tag, resp_ready,
        output req_ready, resp_valid, resp_y, resp_tag, resp_exc
    );
endinterface

// File: rtl/fsqrt_issue.sv
// Requester side of the fsqrt pipeline.
// Issues core requests straight into a fixed-latency, non-stalling fsqrt
// unit, tracks each operation's tag through a valid/tag shift register that
// mirrors the unit's latency, and parks results in a small FIFO so the core
// can back-pressure without losing any. A credit check (in-flight plus
// buffered < DEPTH) guarantees the FIFO always has room when a result lands.
// DEPTH must be a power of two (>= 2) so the pointers wrap modulo 2*DEPTH.
// The interface instance bound to `core` must use the same TAG_W.
module fsqrt_issue #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    fsqrt_issue_if.slave core,
    output logic [31:0] sq_x,
    output logic        sq_enable_in,
    input  logic [31:0] sq_y,
    input  logic        sq_enable_out,
    input  logic        sq_exception,
    output logic        exc_sticky,
    input  logic        exc_clr,
    output logic        proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + LATENCY + 1);
    localparam int MW = $clog2(LATENCY + 1);
    localparam int EW = 32 + TAG_W + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [MW-1:0] MASK_DONE = MW'(LATENCY);

    // Valid/tag pipe aligned with the fsqrt unit's internal pipeline.
    logic [LATENCY-1:0] r_vpipe;
    logic [TAG_W-1:0]   r_tpipe [LATENCY];

    // Result FIFO.
    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    // Post-reset mask counter: 0 right after reset, saturates at LATENCY.
    logic [MW-1:0] r_mask_cnt;
    logic          r_exc_sticky;
    logic          r_proto_err;

    logic              w_live;
    logic              w_check_en;
    logic              w_ready;
    logic              w_accept;
    logic              w_vq;
    logic [TAG_W-1:0]  w_tq;
    logic              w_push;
    logic              w_pop;
    logic [PW-1:0]     w_count;
    logic [CW-1:0]     w_inflight;
    logic [CW-1:0]     w_used;

    // Grant requests only once out of reset and only while a credit is free;
    // the decision uses registered state alone, never req_valid.
    assign w_live     = (r_mask_cnt != '0);
    assign w_check_en = (r_mask_cnt == MASK_DONE);
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_used     = w_inflight + CW'(w_count);
    assign w_ready    = w_live && (w_used < DEPTH_C);
    assign w_accept   = core.req_valid && w_ready;

    assign core.req_ready = w_ready;
    assign sq_enable_in   = w_accept;
    assign sq_x           = core.req_x;

    assign w_vq   = r_vpipe[LATENCY-1];
    assign w_tq   = r_tpipe[LATENCY-1];
    assign w_push = w_vq;
    assign w_pop  = core.resp_valid && core.resp_ready;

    assign core.resp_valid = (w_count != '0);
    assign {core.resp_y, core.resp_tag, core.resp_exc} = r_mem[r_rd_ptr[AW-1:0]];

    assign exc_sticky = r_exc_sticky;
    assign proto_err  = r_proto_err;

    // Count operations currently inside the fsqrt unit.
    // NOTE: a combinational block assigns every output a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_vpipe[i]);
        end
    end

    // Shift the valid bits; stage 0 takes this cycle's accept.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    // Shift the tags alongside the valid bits.
    // NOTE: tag and FIFO storage carry no reset; their contents are only ever qualified by reset-cleared valid bits and pointers.
    always_ff @(posedge clk) begin
        r_tpipe[0] <= core.req_tag;
        for (int i = 1; i < LATENCY; i++) begin
            r_tpipe[i] <= r_tpipe[i-1];
        end
    end

    // Write a returning result, paired with its tag, into the FIFO.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {sq_y, w_tq, sq_exception};
        end
    end

    // Advance FIFO pointers on push and pop; both may happen together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Count cycles since reset release; the fsqrt enables are unreset and
    // may carry stale strobes until the pipeline has flushed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mask_cnt <= '0;
        end else if (r_mask_cnt != MASK_DONE) begin
            r_mask_cnt <= r_mask_cnt + MW'(1);
        end
    end

    // Sticky exception for FCSR: set on retiring an exception, set beats clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_exc_sticky <= 1'b0;
        end else if (w_pop && core.resp_exc) begin
            r_exc_sticky <= 1'b1;
        end else if (exc_clr) begin
            r_exc_sticky <= 1'b0;
        end
    end

    // Flag any disagreement between our valid pipe and the unit's strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_proto_err <= 1'b0;
        end else if (w_check_en && (w_vq != sq_enable_out)) begin
            r_proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fsqrt_issue.sv
// Bench for fsqrt_issue: directed scenarios plus a randomized run scored
// against a transaction-level model (credit count, ordered result queue
// with availability time, sticky-flag model). A behavioural fsqrt unit with
// fixed latency and unreset enables answers the DUT's issues.
module tb_fsqrt_issue;

    localparam int LATENCY = 2;
    localparam int TAG_W   = 5;
    localparam int DEPTH   = 4;
    localparam int NOPS    = 12;

    typedef struct {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             exc;
        int               avail;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] sq_x;
    logic        sq_enable_in;
    logic [31:0] sq_y;
    logic        sq_enable_out;
    logic        sq_exception;
    logic        exc_sticky;
    logic        exc_clr;
    logic        proto_err;
    logic        inject;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ops_tab [NOPS] = '{
        32'h00000000, 32'h80000000, 32'h3F800000, 32'h40000000,
        32'h40800000, 32'h41100000, 32'h41800000, 32'h3E800000,
        32'h42C80000, 32'h7F800000, 32'hBF800000, 32'hC0800000
    };

    always #5 clk = ~clk;

    fsqrt_issue_if #(.TAG_W(TAG_W)) bus ();

    fsqrt_issue #(.LATENCY(LATENCY), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .core          (bus.slave),
        .sq_x          (sq_x),
        .sq_enable_in  (sq_enable_in),
        .sq_y          (sq_y),
        .sq_enable_out (sq_enable_out),
        .sq_exception  (sq_exception),
        .exc_sticky    (exc_sticky),
        .exc_clr       (exc_clr),
        .proto_err     (proto_err)
    );

    // Square root of the operands used here, as {result, invalid-exception}.
    function automatic logic [32:0] ref_sqrt(input logic [31:0] x);
        case (x)
            32'h00000000: return {32'h00000000, 1'b0};
            32'h80000000: return {32'h80000000, 1'b0};
            32'h3F800000: return {32'h3F800000, 1'b0};
            32'h40000000: return {32'h3FB504F3, 1'b0};
            32'h40800000: return {32'h40000000, 1'b0};
            32'h41100000: return {32'h40400000, 1'b0};
            32'h41800000: return {32'h40800000, 1'b0};
            32'h3E800000: return {32'h3F000000, 1'b0};
            32'h42C80000: return {32'h41200000, 1'b0};
            32'h7F800000: return {32'h7F800000, 1'b0};
            32'hBF800000: return {32'hFFC00000, 1'b1};
            32'hC0800000: return {32'hFFC00000, 1'b1};
            default:      return {32'h7FC00000, 1'b1};
        endcase
    endfunction

    // Behavioural fsqrt unit: fixed latency, no stall, enables not reset.
    logic [1:0]  s_v = 2'b00;
    logic [31:0] s_x0 = '0;
    logic [31:0] s_x1 = '0;
    logic [32:0] s_res;
    always @(posedge clk) begin
        s_v  <= {s_v[0], sq_enable_in};
        s_x0 <= sq_x;
        s_x1 <= s_x0;
    end
    assign s_res         = ref_sqrt(s_x1);
    assign sq_y          = s_res[32:1];
    assign sq_exception  = s_res[0] & s_v[1];
    assign sq_enable_out = s_v[1] | inject;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_x      = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        exc_clr        = 1'b0;
        inject         = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
        cyc(LATENCY + 1);
    endtask

    task automatic issue(input logic [31:0] x, input logic [TAG_W-1:0] tag);
        bus.req_valid = 1'b1;
        bus.req_x     = x;
        bus.req_tag   = tag;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        bus.req_valid = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
        n_checks++; if (sq_enable_in !== 1'b0) begin n_fail++; $display("FAIL rst_sq_enable_in: got %b want 0", sq_enable_in); end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        n_checks++; if (exc_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_exc_sticky: got %b want 0", exc_sticky); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_proto_err: got %b want 0", proto_err); end
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_after_edge: got %b want 0", bus.req_ready); end
        bus.req_valid = 1'b0;
        rstn = 1'b1;
        cyc(1);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after_release: got %b want 1", bus.req_ready); end
        cyc(LATENCY);
    endtask

    task automatic test_single();
        logic [32:0] r;
        r = ref_sqrt(32'h40800000);
        bus.resp_ready = 1'b1;
        issue(32'h40800000, 5'd3);
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL t1_req_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (sq_enable_in !== 1'b1) begin n_fail++; $display("FAIL t1_sq_enable_in: got %b want 1", sq_enable_in); end
        n_checks++; if (sq_x !== 32'h40800000) begin n_fail++; $display("FAIL t1_sq_x: got %h want 40800000", sq_x); end
        cyc(1);
        bus.req_valid = 1'b0;
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_early_t1: got %b want 0", bus.resp_valid); end
        cyc(1);
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_early_t2: got %b want 0", bus.resp_valid); end
        cyc(1);
        n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid_t3: got %b want 1", bus.resp_valid); end
        n_checks++; if (bus.resp_y !== r[32:1]) begin n_fail++; $display("FAIL t1_y: got %h want %h", bus.resp_y, r[32:1]); end
        n_checks++; if (bus.resp_tag !== 5'd3) begin n_fail++; $display("FAIL t1_tag: got %0d want 3", bus.resp_tag); end
        n_checks++; if (bus.resp_exc !== 1'b0) begin n_fail++; $display("FAIL t1_exc: got %b want 0", bus.resp_exc); end
        cyc(1);
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_after_pop: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0]      xs   [3];
        logic [TAG_W-1:0] tags [3];
        logic [32:0]      r;
        xs[0] = 32'h40000000; xs[1] = 32'h3F800000; xs[2] = 32'h00000000;
        tags[0] = 5'd7; tags[1] = 5'd8; tags[2] = 5'd9;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(xs[i], tags[i]);
            #1;
            n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.req_ready); end
            cyc(1);
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r = ref_sqrt(xs[i]);
            n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.resp_valid); end
            n_checks++; if (bus.resp_y !== r[32:1]) begin n_fail++; $display("FAIL b2b_y[%0d]: got %h want %h", i, bus.resp_y, r[32:1]); end
            n_checks++; if (bus.resp_tag !== tags[i]) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, bus.resp_tag, tags[i]); end
            cyc(1);
        end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_exception();
        exc_clr = 1'b0;
        bus.resp_ready = 1'b1;
        issue(32'hBF800000, 5'd12);
        cyc(1);
        bus.req_valid = 1'b0;
        cyc(2);
        n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL exc_valid: got %b want 1", bus.resp_valid); end
        n_checks++; if (bus.resp_y !== 32'hFFC00000) begin n_fail++; $display("FAIL exc_y: got %h want ffc00000", bus.resp_y); end
        n_checks++; if (bus.resp_exc !== 1'b1) begin n_fail++; $display("FAIL exc_bit: got %b want 1", bus.resp_exc); end
        n_checks++; if (exc_sticky !== 1'b0) begin n_fail++; $display("FAIL exc_sticky_before_pop: got %b want 0", exc_sticky); end
        cyc(1);
        n_checks++; if (exc_sticky !== 1'b1) begin n_fail++; $display("FAIL exc_sticky_after_pop: got %b want 1", exc_sticky); end
        // Second exception held at the head, then popped together with a clear.
        bus.resp_ready = 1'b0;
        issue(32'hC0800000, 5'd13);
        cyc(1);
        bus.req_valid = 1'b0;
        cyc(2);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL exc_hold_valid[%0d]: got %b want 1", i, bus.resp_valid); end
            n_checks++; if (bus.resp_tag !== 5'd13) begin n_fail++; $display("FAIL exc_hold_tag[%0d]: got %0d want 13", i, bus.resp_tag); end
            n_checks++; if (bus.resp_y !== 32'hFFC00000) begin n_fail++; $display("FAIL exc_hold_y[%0d]: got %h want ffc00000", i, bus.resp_y); end
            cyc(1);
        end
        bus.resp_ready = 1'b1;
        exc_clr = 1'b1;
        cyc(1);
        exc_clr = 1'b0;
        n_checks++; if (exc_sticky !== 1'b1) begin n_fail++; $display("FAIL exc_set_wins: got %b want 1", exc_sticky); end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL exc_popped: got %b want 0", bus.resp_valid); end
        exc_clr = 1'b1;
        cyc(1);
        exc_clr = 1'b0;
        n_checks++; if (exc_sticky !== 1'b0) begin n_fail++; $display("FAIL exc_clear: got %b want 0", exc_sticky); end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t e;
        logic [32:0] r;
        int accepted;
        accepted = 0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(ops_tab[$urandom_range(0, NOPS-1)], TAG_W'(16 + i));
            #1;
            if (bus.req_valid && bus.req_ready) begin
                r = ref_sqrt(bus.req_x);
                e.y = r[32:1]; e.tag = bus.req_tag; e.exc = r[0]; e.avail = 0;
                q.push_back(e);
                accepted++;
            end
            cyc(1);
        end
        bus.req_valid = 1'b0;
        n_checks++; if (accepted != DEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d want %0d", accepted, DEPTH); end
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", bus.req_ready); end
        cyc(2);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            #1;
            n_checks++; if (bus.req_ready !== (i != 0)) begin n_fail++; $display("FAIL bp_ready_pop[%0d]: got %b want %b", i, bus.req_ready, (i != 0)); end
            n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.resp_valid); end
            n_checks++; if (bus.resp_y !== q[i].y) begin n_fail++; $display("FAIL bp_y[%0d]: got %h want %h", i, bus.resp_y, q[i].y); end
            n_checks++; if (bus.resp_tag !== q[i].tag) begin n_fail++; $display("FAIL bp_tag[%0d]: got %0d want %0d", i, bus.resp_tag, q[i].tag); end
            n_checks++; if (bus.resp_exc !== q[i].exc) begin n_fail++; $display("FAIL bp_exc[%0d]: got %b want %b", i, bus.resp_exc, q[i].exc); end
            cyc(1);
        end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", bus.resp_valid); end
        exc_clr = 1'b1;
        cyc(1);
        exc_clr = 1'b0;
    endtask

    task automatic test_reset_midop();
        bus.resp_ready = 1'b0;
        issue(32'h40800000, 5'd1);
        cyc(1);
        issue(32'h41100000, 5'd2);
        cyc(1);
        issue(32'h41800000, 5'd3);
        cyc(1);
        bus.req_valid = 1'b0;
        n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered: got %b want 1", bus.resp_valid); end
        rstn = 1'b0;
        #1;
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_in_reset: got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b want 0", bus.req_ready); end
        @(negedge clk);
        rstn = 1'b1;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_resp[%0d]: got %b want 0", i, bus.resp_valid); end
            n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL mid_proto_err[%0d]: got %b want 0", i, proto_err); end
        end
        issue(32'h41800000, 5'd21);
        cyc(1);
        bus.req_valid = 1'b0;
        cyc(2);
        n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_next_valid: got %b want 1", bus.resp_valid); end
        n_checks++; if (bus.resp_y !== 32'h40800000) begin n_fail++; $display("FAIL mid_next_y: got %h want 40800000", bus.resp_y); end
        n_checks++; if (bus.resp_tag !== 5'd21) begin n_fail++; $display("FAIL mid_next_tag: got %0d want 21", bus.resp_tag); end
        cyc(1);
    endtask

    task automatic test_proto_err();
        idle_inputs();
        cyc(2);
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_clean: got %b want 0", proto_err); end
        inject = 1'b1;
        cyc(1);
        inject = 1'b0;
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b want 1", proto_err); end
        cyc(3);
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_held: got %b want 1", proto_err); end
        rstn = 1'b0;
        #1;
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_reset: got %b want 0", proto_err); end
        @(negedge clk);
        rstn = 1'b1;
        cyc(LATENCY + 1);
    endtask

    task automatic test_random();
        exp_t        sb[$];
        exp_t        e;
        logic [32:0] r;
        int          outstanding;
        int          total_acc;
        logic        m_sticky;
        logic        exp_ready;
        logic        exp_valid;
        logic        acc;
        logic        pop;
        apply_reset();
        outstanding = 0;
        total_acc   = 0;
        m_sticky    = 1'b0;
        for (int c = 0; c < 620; c++) begin
            bus.req_valid  = (c < 600) && ($urandom_range(0, 9) < 7);
            bus.req_x      = ops_tab[$urandom_range(0, NOPS-1)];
            bus.req_tag    = TAG_W'($urandom);
            bus.resp_ready = (c < 600) ? ($urandom_range(0, 9) < 6) : 1'b1;
            exc_clr        = ($urandom_range(0, 9) == 0);
            #1;
            exp_ready = (outstanding < DEPTH);
            acc       = bus.req_valid && exp_ready;
            exp_valid = (sb.size() > 0) && (sb[0].avail <= c);
            pop       = exp_valid && bus.resp_ready;
            n_checks++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, bus.req_ready, exp_ready); end
            n_checks++; if (sq_enable_in !== acc) begin n_fail++; $display("FAIL rnd_issue c=%0d: got %b want %b", c, sq_enable_in, acc); end
            n_checks++; if (bus.resp_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, bus.resp_valid, exp_valid); end
            n_checks++; if (exc_sticky !== m_sticky) begin n_fail++; $display("FAIL rnd_sticky c=%0d: got %b want %b", c, exc_sticky, m_sticky); end
            if (pop) begin
                n_checks++;
                if (bus.resp_y !== sb[0].y || bus.resp_tag !== sb[0].tag || bus.resp_exc !== sb[0].exc) begin
                    n_fail++;
                    $display("FAIL rnd_resp c=%0d: got %h/%0d/%b want %h/%0d/%b", c,
                             bus.resp_y, bus.resp_tag, bus.resp_exc, sb[0].y, sb[0].tag, sb[0].exc);
                end
                if (sb[0].exc) m_sticky = 1'b1;
                else if (exc_clr) m_sticky = 1'b0;
                void'(sb.pop_front());
                outstanding--;
            end else if (exc_clr) begin
                m_sticky = 1'b0;
            end
            if (acc) begin
                r = ref_sqrt(bus.req_x);
                e.y = r[32:1]; e.tag = bus.req_tag; e.exc = r[0]; e.avail = c + LATENCY + 1;
                sb.push_back(e);
                outstanding++;
                total_acc++;
            end
            cyc(1);
        end
        idle_inputs();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rnd_leftover: got %0d want 0", sb.size()); end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_final_valid: got %b want 0", bus.resp_valid); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rnd_proto_err: got %b want 0", proto_err); end
        n_checks++; if (total_acc < 200) begin n_fail++; $display("FAIL rnd_activity: got %0d accepts want >= 200", total_acc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_exception();
        test_backpressure();
        test_reset_midop();
        test_random();
        test_proto_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
